pc_ctrl: RTL and testbench
==========================

PC_CTRL -- requirements
Module: pc_ctrl

Interface
REQ-001 The block SHALL have parameter START_ADDR, default 11'h000, the PC load value on program start.
REQ-002 The block SHALL have port CLK  input  1  system clock; all state changes on its rising edge.
REQ-003 The block SHALL have port Reset  input  1  reset, synchronous and active-high.
REQ-004 The block SHALL have port start  input  1  begin or restart program execution.
REQ-005 The block SHALL have port halt  input  1  the current instruction is a halt.
REQ-006 The block SHALL have port jmp  input  1  the current instruction is an absolute jump.
REQ-007 The block SHALL have port branch  input  1  the current instruction is a relative conditional branch.
REQ-008 The block SHALL have port cond  input  1  branch condition flag from the ALU.
REQ-009 The block SHALL have port idx_in  input  6  jump/branch label index field from the instruction.
REQ-010 The block SHALL have port lut_index  output  6  index presented to the target lookup table.
REQ-011 The block SHALL have port lut_jmp  output  1  absolute/relative select presented to the lookup table.
REQ-012 The block SHALL have port lut_out  input  11  target or offset returned by the lookup table.
REQ-013 The block SHALL have port pc  output  11  current instruction address, registered.
REQ-014 The block SHALL have port busy  output  1  high while in RUN.
REQ-015 The block SHALL have port done  output  1  high while in DONE.
REQ-016 The block SHALL have port icount  output  16  count of instructions retired since the last start, registered.

Function
REQ-017 The block SHALL drive lut_index = idx_in and lut_jmp = jmp combinationally, with zero latency.
REQ-018 The block SHALL implement a three-state FSM with states IDLE, RUN and DONE.
REQ-019 In IDLE, on start=1 the block SHALL go to RUN and load pc=START_ADDR and icount=0; otherwise it SHALL hold all registers.
REQ-020 In RUN, the block SHALL evaluate one instruction per cycle with priority halt > jmp > branch > sequential.
REQ-021 In RUN with halt=1, the block SHALL go to DONE, hold pc, and increment icount.
REQ-022 In RUN with jmp=1 and halt=0, the block SHALL load pc=lut_out (absolute).
REQ-023 In RUN with branch=1, cond=1 and jmp=0, the block SHALL load pc = pc + lut_out, treating lut_out as 11-bit two's complement and wrapping modulo 2048.
REQ-024 In RUN with branch=1 and cond=0, or with no control input asserted, the block SHALL load pc = pc + 1, wrapping 11'h7FF to 11'h000.
REQ-025 The block SHALL increment icount once per RUN cycle, saturating at 16'hFFFF.
REQ-026 The block SHALL ignore start while in RUN.
REQ-027 In DONE, the block SHALL hold pc and icount; on start=1 it SHALL go to RUN, load pc=START_ADDR and icount=0, and deassert done on the following cycle.
REQ-028 The block SHALL register busy and done, asserting each in the first cycle of its state.
REQ-029 The block SHALL ignore halt, jmp, branch and cond outside RUN.

Reset
REQ-030 With Reset=1 at a clock edge, the block SHALL enter IDLE with pc=START_ADDR, icount=0, busy=0 and done=0, regardless of state.
REQ-031 Reset SHALL take priority over start and all other inputs in the same cycle.
REQ-032 After Reset deasserts, the block SHALL remain in IDLE until start=1.

Verification
REQ-033 Sequential run: Reset, then start, then 5 cycles with no control inputs, then halt -> pc sequence 0,1,2,3,4,5 then holds 5; done=1, busy=0, icount=6.
REQ-034 Absolute jump: in RUN at pc=3, jmp=1 with lut_out=11'h100 -> next pc=11'h100; lut_jmp=1 in the same cycle; icount increments by 1.
REQ-035 Relative branch: at pc=11'h010, branch=1 with cond=1 and lut_out=11'h7FC (-4) -> pc=11'h00C; with cond=0 -> pc=11'h011.
REQ-036 Wrap: at pc=11'h7FF with no control inputs -> pc=11'h000; at pc=11'h7FE with a taken branch of offset 11'h003 -> pc=11'h001.
REQ-037 Priority and idle: halt, jmp and branch asserted together in RUN -> DONE with pc held; start while in RUN -> no effect; controls asserted in IDLE -> pc stays 0.
REQ-038 Reset mid-run: Reset at pc=11'h020 with icount=9 -> next cycle IDLE, pc=0, icount=0, busy=0; a following start -> RUN from 0.

Source files
------------

// File: rtl/pc_ctrl.sv
// Program counter controller: sequences instruction addresses through
// IDLE/RUN/DONE, resolving halt, absolute jumps and relative branches.
module pc_ctrl #(
    parameter logic [10:0] START_ADDR = 11'h000
) (
    input  logic        CLK,
    input  logic        Reset,
    input  logic        start,
    input  logic        halt,
    input  logic        jmp,
    input  logic        branch,
    input  logic        cond,
    input  logic [5:0]  idx_in,
    output logic [5:0]  lut_index,
    output logic        lut_jmp,
    input  logic [10:0] lut_out,
    output logic [10:0] pc,
    output logic        busy,
    output logic        done,
    output logic [15:0] icount,
    output logic [1:0]  state_dbg
);

    // No handshake: start is a level request sampled on every rising edge;
    // control inputs describe the instruction at pc and are consumed only in RUN.
    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_t;

    state_t      state;
    state_t      next_state;
    logic [10:0] pc_next;
    logic [15:0] icount_next;

    assign lut_index = idx_in;
    assign lut_jmp   = jmp;
    assign state_dbg = state;

    always_comb begin
        next_state  = state;
        pc_next     = pc;
        icount_next = icount;
        case (state)
            IDLE, DONE: begin
                if (start) begin
                    next_state  = RUN;
                    pc_next     = START_ADDR;
                    icount_next = 16'h0000;
                end
            end
            RUN: begin
                icount_next = (icount == 16'hFFFF) ? icount : icount + 16'd1;
                if (halt) begin
                    next_state = DONE;
                end else if (jmp) begin
                    pc_next = lut_out;
                end else if (branch && cond) begin
                    // lut_out is a two's complement offset; 11-bit add wraps naturally
                    pc_next = pc + lut_out;
                end else begin
                    pc_next = pc + 11'd1;
                end
            end
            default: begin
                next_state = IDLE;
            end
        endcase
    end

    always_ff @(posedge CLK) begin
        if (Reset) begin
            state  <= IDLE;
            pc     <= START_ADDR;
            icount <= 16'h0000;
            busy   <= 1'b0;
            done   <= 1'b0;
        end else begin
            state  <= next_state;
            pc     <= pc_next;
            icount <= icount_next;
            busy   <= (next_state == RUN);
            done   <= (next_state == DONE);
        end
    end

endmodule

// File: tb/tb_pc_ctrl.sv
// Bench for pc_ctrl: directed scenarios plus random instruction streams,
// checked against a behavioural program-counter model through a scoreboard.
module tb_pc_ctrl;

    localparam logic [10:0] START = 11'h000;

    logic        CLK = 1'b0;
    logic        Reset, start, halt, jmp, branch, cond;
    logic [5:0]  idx_in, lut_index;
    logic        lut_jmp, busy, done;
    logic [10:0] lut_out, pc;
    logic [15:0] icount;
    logic [1:0]  state_dbg;

    int checks = 0;
    int failures = 0;

    // expected {busy, done, icount, pc} after each clock edge
    logic [28:0] exp_q[$];

    // behavioural model
    bit m_run, m_fin;
    int m_pc, m_cnt;

    pc_ctrl #(.START_ADDR(START)) dut (
        .CLK(CLK), .Reset(Reset), .start(start), .halt(halt), .jmp(jmp),
        .branch(branch), .cond(cond), .idx_in(idx_in), .lut_index(lut_index),
        .lut_jmp(lut_jmp), .lut_out(lut_out), .pc(pc), .busy(busy),
        .done(done), .icount(icount), .state_dbg(state_dbg)
    );

    // clock / reset block
    always #5 CLK = ~CLK;

    initial begin
        Reset = 1'b1; start = 0; halt = 0; jmp = 0; branch = 0; cond = 0;
        idx_in = 0; lut_out = 0;
    end

    function automatic int wrap_add(input int base, input int raw);
        int off;
        off = (raw >= 1024) ? raw - 2048 : raw;
        return (base + off + 4096) % 2048;
    endfunction

    // driver: apply one cycle of inputs, check the lookup passthrough,
    // advance the model and queue the expected post-edge outputs
    task automatic step(input bit rst, input bit st, input bit h, input bit j,
                        input bit b, input bit c, input logic [5:0] idx,
                        input logic [10:0] lo);
        Reset = rst; start = st; halt = h; jmp = j; branch = b; cond = c;
        idx_in = idx; lut_out = lo;
        #1;
        checks++;
        if (lut_index !== idx || lut_jmp !== j) begin
            failures++;
            $display("FAIL lut_passthru: got idx=%h jmp=%b, expected idx=%h jmp=%b",
                     lut_index, lut_jmp, idx, j);
        end
        if (rst) begin
            m_run = 0; m_fin = 0; m_pc = START; m_cnt = 0;
        end else if (!m_run) begin
            if (st) begin
                m_run = 1; m_fin = 0; m_pc = START; m_cnt = 0;
            end
        end else begin
            if (m_cnt < 65535) m_cnt++;
            if (h) begin
                m_run = 0; m_fin = 1;
            end else if (j) m_pc = lo;
            else if (b && c) m_pc = wrap_add(m_pc, lo);
            else m_pc = (m_pc + 1) % 2048;
        end
        exp_q.push_back({m_run, m_fin, 16'(m_cnt), 11'(m_pc)});
        @(posedge CLK);
        #2;
    endtask

    task automatic idle_cyc(input int n);
        for (int i = 0; i < n; i++) step(0, 0, 0, 0, 0, 0, 6'h00, 11'h000);
    endtask

    task automatic do_jmp(input logic [10:0] tgt);
        step(0, 0, 0, 1, 0, 0, 6'h05, tgt);
    endtask

    // monitor / scoreboard: outputs are presented every cycle
    always @(posedge CLK) begin
        logic [28:0] e;
        #1;
        if (exp_q.size() > 0) begin
            e = exp_q.pop_front();
            checks++;
            if ({busy, done, icount, pc} !== e) begin
                failures++;
                $display("FAIL outputs: got busy=%b done=%b icount=%0d pc=%h, expected busy=%b done=%b icount=%0d pc=%h",
                         busy, done, icount, pc, e[28], e[27], e[26:11], e[10:0]);
            end
        end
    end

    initial begin
        int wait_cnt;
        #1;
        // reset state
        step(1, 0, 0, 0, 0, 0, 6'h00, 11'h000);
        step(1, 1, 1, 1, 1, 1, 6'h3F, 11'h7FF);
        idle_cyc(2);

        // sequential run then halt, holding afterwards
        step(0, 1, 0, 0, 0, 0, 6'h00, 11'h000);
        idle_cyc(5);
        step(0, 0, 1, 0, 0, 0, 6'h00, 11'h000);
        idle_cyc(2);

        // absolute jump from pc=3
        step(0, 1, 0, 0, 0, 0, 6'h00, 11'h000);
        idle_cyc(3);
        step(0, 0, 0, 1, 0, 0, 6'h2A, 11'h100);

        // relative branch taken / not taken
        do_jmp(11'h010);
        step(0, 0, 0, 0, 1, 1, 6'h11, 11'h7FC);
        do_jmp(11'h010);
        step(0, 0, 0, 0, 1, 0, 6'h11, 11'h7FC);

        // wrap cases
        do_jmp(11'h7FF);
        idle_cyc(1);
        do_jmp(11'h7FE);
        step(0, 0, 0, 0, 1, 1, 6'h01, 11'h003);

        // start ignored in RUN; all controls together halt
        step(0, 1, 0, 0, 0, 0, 6'h00, 11'h000);
        step(0, 0, 1, 1, 1, 1, 6'h07, 11'h123);
        step(0, 0, 0, 1, 1, 1, 6'h08, 11'h456);

        // controls in IDLE
        step(1, 0, 0, 0, 0, 0, 6'h00, 11'h000);
        step(0, 0, 0, 1, 0, 0, 6'h09, 11'h321);
        step(0, 0, 0, 0, 1, 1, 6'h0A, 11'h005);
        step(0, 0, 1, 0, 0, 0, 6'h0B, 11'h000);

        // reset mid-run at pc=0x020, icount=9, then restart
        step(0, 1, 0, 0, 0, 0, 6'h00, 11'h000);
        idle_cyc(7);
        do_jmp(11'h01F);
        idle_cyc(1);
        step(1, 1, 0, 0, 0, 0, 6'h00, 11'h000);
        step(0, 1, 0, 0, 0, 0, 6'h00, 11'h000);
        idle_cyc(2);

        // random instruction streams
        for (int i = 0; i < 600; i++) begin
            bit r, s, h, j, b, c;
            r = ($urandom_range(0, 99) < 2);
            s = ($urandom_range(0, 99) < 15);
            h = ($urandom_range(0, 99) < 6);
            j = ($urandom_range(0, 99) < 20);
            b = ($urandom_range(0, 99) < 30);
            c = $urandom_range(0, 1);
            step(r, s, h, j, b, c, 6'($urandom_range(0, 63)), 11'($urandom_range(0, 2047)));
        end

        // drain scoreboard with a bounded wait
        wait_cnt = 0;
        while (exp_q.size() > 0 && wait_cnt < 10) begin
            @(posedge CLK);
            #2;
            wait_cnt++;
        end
        checks++;
        if (exp_q.size() != 0) begin
            failures++;
            $display("FAIL drain: got %0d pending, expected 0", exp_q.size());
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
